// File: rtl/tomasulo_add_rs_if.sv
`default_nettype none
// ============================================================================
// Module   : tomasulo_add_rs_if
// Function : Issue, CDB and execute-dispatch signal bundle for the ADD
//            reservation station.
// Revision : 1.0 - initial release
// ============================================================================
interface tomasulo_add_rs_if #(
    parameter int DATA_W = 32
);
    logic              issue_valid;
    logic              issue_op;
    logic [DATA_W-1:0] issue_vj;
    logic [DATA_W-1:0] issue_vk;
    logic [4:0]        issue_qj;
    logic [4:0]        issue_qk;
    logic              issue_ready;
    logic [4:0]        issue_tag;

    logic              cdb_valid;
    logic [4:0]        cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              ex_valid;
    logic              ex_ready;
    logic              ex_op;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [4:0]        ex_tag;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
        input  issue_ready, issue_tag,
        output cdb_valid, cdb_tag, cdb_data,
        input  ex_valid, ex_op, ex_a, ex_b, ex_tag,
        output ex_ready
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
        output issue_ready, issue_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        output ex_valid, ex_op, ex_a, ex_b, ex_tag,
        input  ex_ready
    );
endinterface
`default_nettype wire

// File: rtl/tomasulo_add_rs.sv
`default_nettype none
// ============================================================================
// Module   : tomasulo_add_rs
// Function : Reservation station feeding the ADD unit; captures operands from
//            issue and CDB, dispatches ready entries, frees on own broadcast.
// Revision : 1.0 - initial release
// ============================================================================
module tomasulo_add_rs #(
    parameter logic [2:0] RS_ID   = 3'b010,
    parameter int         ENTRIES = 3,
    parameter int         DATA_W  = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    tomasulo_add_rs_if.slave  bus
);

    localparam int         C_IDX_W    = 2;
    localparam logic [1:0] C_ST_FREE  = 2'd0;
    localparam logic [1:0] C_ST_WAIT  = 2'd1;
    localparam logic [1:0] C_ST_READY = 2'd2;
    localparam logic [1:0] C_ST_EXEC  = 2'd3;

    logic [1:0]         r_state [ENTRIES];
    logic               r_op    [ENTRIES];
    logic [DATA_W-1:0]  r_vj    [ENTRIES];
    logic [DATA_W-1:0]  r_vk    [ENTRIES];
    logic [4:0]         r_qj    [ENTRIES];
    logic [4:0]         r_qk    [ENTRIES];

    logic [1:0]         w_state_nxt [ENTRIES];
    logic               w_op_nxt    [ENTRIES];
    logic [DATA_W-1:0]  w_vj_nxt    [ENTRIES];
    logic [DATA_W-1:0]  w_vk_nxt    [ENTRIES];
    logic [4:0]         w_qj_nxt    [ENTRIES];
    logic [4:0]         w_qk_nxt    [ENTRIES];

    logic               r_ex_valid;
    logic [C_IDX_W-1:0] r_ex_idx;
    logic               r_ex_op;
    logic [DATA_W-1:0]  r_ex_a;
    logic [DATA_W-1:0]  r_ex_b;
    logic [4:0]         r_ex_tag;

    logic               w_free_found;
    logic [C_IDX_W-1:0] w_free_idx;
    logic               w_issue_fire;
    logic               w_cdb_hit;
    logic               w_handshake;
    logic               w_take;
    logic [4:0]         w_iss_qj;
    logic [4:0]         w_iss_qk;
    logic [DATA_W-1:0]  w_iss_vj;
    logic [DATA_W-1:0]  w_iss_vk;

    logic               w_sel_found;
    logic [C_IDX_W-1:0] w_sel_idx;
    logic               w_sel_op;
    logic [DATA_W-1:0]  w_sel_a;
    logic [DATA_W-1:0]  w_sel_b;

    // Issue slot is derived only from registered state, so a same-cycle free
    // never makes room for a same-cycle issue.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_state[i] == C_ST_FREE) begin
                w_free_found = 1'b1;
                w_free_idx   = C_IDX_W'(i);
            end
        end
    end

    assign bus.issue_ready = w_free_found;
    assign bus.issue_tag   = {RS_ID, w_free_idx};

    assign w_issue_fire = bus.issue_valid && w_free_found;
    assign w_cdb_hit    = bus.cdb_valid && (bus.cdb_tag != 5'd0);
    assign w_handshake  = r_ex_valid && bus.ex_ready;
    assign w_take       = !r_ex_valid || w_handshake;

    // Issue-time bypass: a broadcast in the issue cycle resolves the operand.
    assign w_iss_qj = (w_cdb_hit && bus.issue_qj == bus.cdb_tag) ? 5'd0 : bus.issue_qj;
    assign w_iss_qk = (w_cdb_hit && bus.issue_qk == bus.cdb_tag) ? 5'd0 : bus.issue_qk;
    assign w_iss_vj = (w_cdb_hit && bus.issue_qj == bus.cdb_tag) ? bus.cdb_data : bus.issue_vj;
    assign w_iss_vk = (w_cdb_hit && bus.issue_qk == bus.cdb_tag) ? bus.cdb_data : bus.issue_vk;

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_vj_nxt    = r_vj;
        w_vk_nxt    = r_vk;
        w_qj_nxt    = r_qj;
        w_qk_nxt    = r_qk;
        for (int i = 0; i < ENTRIES; i++) begin
            case (r_state[i])
                C_ST_FREE: begin
                    if (w_issue_fire && w_free_idx == C_IDX_W'(i)) begin
                        w_op_nxt[i]    = bus.issue_op;
                        w_vj_nxt[i]    = w_iss_vj;
                        w_vk_nxt[i]    = w_iss_vk;
                        w_qj_nxt[i]    = w_iss_qj;
                        w_qk_nxt[i]    = w_iss_qk;
                        w_state_nxt[i] = (w_iss_qj == 5'd0 && w_iss_qk == 5'd0)
                                         ? C_ST_READY : C_ST_WAIT;
                    end
                end
                C_ST_WAIT: begin
                    if (w_cdb_hit && r_qj[i] == bus.cdb_tag) begin
                        w_vj_nxt[i] = bus.cdb_data;
                        w_qj_nxt[i] = 5'd0;
                    end
                    if (w_cdb_hit && r_qk[i] == bus.cdb_tag) begin
                        w_vk_nxt[i] = bus.cdb_data;
                        w_qk_nxt[i] = 5'd0;
                    end
                    if (w_qj_nxt[i] == 5'd0 && w_qk_nxt[i] == 5'd0) begin
                        w_state_nxt[i] = C_ST_READY;
                    end
                end
                C_ST_READY: begin
                    if (w_handshake && r_ex_idx == C_IDX_W'(i)) begin
                        w_state_nxt[i] = C_ST_EXEC;
                    end
                end
                default: begin
                    if (w_cdb_hit && bus.cdb_tag == {RS_ID, C_IDX_W'(i)}) begin
                        w_state_nxt[i] = C_ST_FREE;
                    end
                end
            endcase
        end
    end

    // Selection looks at next-cycle readiness so a just-issued or just-woken
    // entry can be presented one cycle later.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_op    = 1'b0;
        w_sel_a     = '0;
        w_sel_b     = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_state_nxt[i] == C_ST_READY) begin
                w_sel_found = 1'b1;
                w_sel_idx   = C_IDX_W'(i);
                w_sel_op    = w_op_nxt[i];
                w_sel_a     = w_vj_nxt[i];
                w_sel_b     = w_vk_nxt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_state[i] <= C_ST_FREE;
                r_op[i]    <= 1'b0;
                r_vj[i]    <= '0;
                r_vk[i]    <= '0;
                r_qj[i]    <= 5'd0;
                r_qk[i]    <= 5'd0;
            end
            r_ex_valid <= 1'b0;
            r_ex_idx   <= '0;
            r_ex_op    <= 1'b0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_tag   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_vj    <= w_vj_nxt;
            r_vk    <= w_vk_nxt;
            r_qj    <= w_qj_nxt;
            r_qk    <= w_qk_nxt;
            if (w_take) begin
                r_ex_valid <= w_sel_found;
                if (w_sel_found) begin
                    r_ex_idx <= w_sel_idx;
                    r_ex_op  <= w_sel_op;
                    r_ex_a   <= w_sel_a;
                    r_ex_b   <= w_sel_b;
                    r_ex_tag <= {RS_ID, w_sel_idx};
                end
            end
        end
    end

    assign bus.ex_valid = r_ex_valid;
    assign bus.ex_op    = r_ex_op;
    assign bus.ex_a     = r_ex_a;
    assign bus.ex_b     = r_ex_b;
    assign bus.ex_tag   = r_ex_tag;

endmodule
`default_nettype wire

// File: tb/tb_tomasulo_add_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_tomasulo_add_rs
// Function : Directed scenarios plus randomized traffic against a behavioural
//            model of the ADD reservation station.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tomasulo_add_rs;

    localparam int C_N = 3;
    localparam int S_FREE = 0, S_WAIT = 1, S_READY = 2, S_EXEC = 3;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    tomasulo_add_rs_if #(.DATA_W(32)) bus ();

    tomasulo_add_rs #(.RS_ID(3'b010), .ENTRIES(C_N), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model state
    int          m_st  [C_N];
    logic        m_op  [C_N];
    logic [31:0] m_vj  [C_N];
    logic [31:0] m_vk  [C_N];
    logic [4:0]  m_qj  [C_N];
    logic [4:0]  m_qk  [C_N];
    logic        m_exv;
    int          m_exi;
    logic        m_exop;
    logic [31:0] m_exa, m_exb;

    task automatic drive(input logic iv, input logic op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [4:0] qj, input logic [4:0] qk, input logic cv,
                         input logic [4:0] ct, input logic [31:0] cd, input logic exr);
        bus.issue_valid = iv; bus.issue_op = op; bus.issue_vj = vj; bus.issue_vk = vk;
        bus.issue_qj = qj; bus.issue_qk = qk;
        bus.cdb_valid = cv; bus.cdb_tag = ct; bus.cdb_data = cd; bus.ex_ready = exr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic exr);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, exr);
    endtask

    task automatic do_reset();
        idle(0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < C_N; i++) begin
            m_st[i] = S_FREE; m_op[i] = 0; m_vj[i] = 0; m_vk[i] = 0; m_qj[i] = 0; m_qk[i] = 0;
        end
        m_exv = 0; m_exi = 0; m_exop = 0; m_exa = 0; m_exb = 0;
    endtask

    // One clock edge of the station expressed directly from its rules.
    task automatic model_step(input logic iv, input logic op, input logic [31:0] vj, input logic [31:0] vk,
                              input logic [4:0] qj, input logic [4:0] qk, input logic cv,
                              input logic [4:0] ct, input logic [31:0] cd, input logic exr);
        int   free_i = -1;
        bit   hit    = cv && (ct != 0);
        bit   hs     = m_exv && exr;
        for (int i = 0; i < C_N; i++) if (m_st[i] == S_FREE && free_i < 0) free_i = i;
        for (int i = 0; i < C_N; i++) begin
            if (m_st[i] == S_EXEC && hit && ct == 5'(8 + i)) m_st[i] = S_FREE;
            else if (m_st[i] == S_WAIT) begin
                if (hit && m_qj[i] == ct) begin m_vj[i] = cd; m_qj[i] = 0; end
                if (hit && m_qk[i] == ct) begin m_vk[i] = cd; m_qk[i] = 0; end
                if (m_qj[i] == 0 && m_qk[i] == 0) m_st[i] = S_READY;
            end
        end
        if (hs) m_st[m_exi] = S_EXEC;
        if (iv && free_i >= 0) begin
            m_op[free_i] = op;
            m_qj[free_i] = (hit && qj == ct) ? 5'd0 : qj;
            m_vj[free_i] = (hit && qj == ct) ? cd : vj;
            m_qk[free_i] = (hit && qk == ct) ? 5'd0 : qk;
            m_vk[free_i] = (hit && qk == ct) ? cd : vk;
            m_st[free_i] = (m_qj[free_i] == 0 && m_qk[free_i] == 0) ? S_READY : S_WAIT;
        end
        if (!m_exv || hs) begin
            m_exv = 0;
            for (int i = C_N - 1; i >= 0; i--) begin
                if (m_st[i] == S_READY) begin
                    m_exv = 1; m_exi = i; m_exop = m_op[i]; m_exa = m_vj[i]; m_exb = m_vk[i];
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %0b want 0", bus.ex_valid); end
        n_checks++; if (bus.ex_op !== 1'b0) begin n_fail++; $display("FAIL reset_ex_op: got %0b want 0", bus.ex_op); end
        n_checks++; if (bus.ex_a !== 32'd0 || bus.ex_b !== 32'd0) begin n_fail++; $display("FAIL reset_ex_ab: got %0d/%0d want 0/0", bus.ex_a, bus.ex_b); end
        n_checks++; if (bus.ex_tag !== 5'd0) begin n_fail++; $display("FAIL reset_ex_tag: got %b want 00000", bus.ex_tag); end
        n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %0b want 1", bus.issue_ready); end
        n_checks++; if (bus.issue_tag !== 5'b01000) begin n_fail++; $display("FAIL reset_issue_tag: got %b want 01000", bus.issue_tag); end
    endtask

    task automatic test_basic_issue();
        do_reset();
        drive(1, 0, 5, 7, 0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.issue_tag !== 5'b01000) begin n_fail++; $display("FAIL basic_issue_tag: got %b want 01000", bus.issue_tag); end
        tick();
        idle(0);
        n_checks++; if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL basic_ex_valid: got %0b want 1", bus.ex_valid); end
        n_checks++; if (bus.ex_a !== 32'd5 || bus.ex_b !== 32'd7) begin n_fail++; $display("FAIL basic_ex_ab: got %0d/%0d want 5/7", bus.ex_a, bus.ex_b); end
        n_checks++; if (bus.ex_tag !== 5'b01000 || bus.ex_op !== 1'b0) begin n_fail++; $display("FAIL basic_ex_tag_op: got %b/%0b want 01000/0", bus.ex_tag, bus.ex_op); end
        n_checks++; if (bus.issue_tag !== 5'b01001) begin n_fail++; $display("FAIL basic_next_tag: got %b want 01001", bus.issue_tag); end
    endtask

    task automatic test_cdb_wakeup();
        do_reset();
        drive(1, 1, 99, 3, 5'b00101, 0, 0, 0, 0, 0);
        tick();
        idle(0);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL wake_wait_%0d: ex_valid got %0b want 0", k, bus.ex_valid); end
        end
        drive(0, 0, 0, 0, 0, 0, 1, 5'b00101, 20, 0);
        n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL wake_bcast_cycle: ex_valid got %0b want 0", bus.ex_valid); end
        tick();
        idle(0);
        n_checks++; if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL wake_ex_valid: got %0b want 1", bus.ex_valid); end
        n_checks++; if (bus.ex_a !== 32'd20 || bus.ex_b !== 32'd3) begin n_fail++; $display("FAIL wake_ex_ab: got %0d/%0d want 20/3", bus.ex_a, bus.ex_b); end
        n_checks++; if (bus.ex_op !== 1'b1) begin n_fail++; $display("FAIL wake_ex_op: got %0b want 1", bus.ex_op); end
    endtask

    task automatic test_bypass();
        do_reset();
        drive(1, 0, 1, 1, 5'b10000, 5'b10000, 1, 5'b10000, 9, 0);
        tick();
        idle(0);
        n_checks++; if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_ex_valid: got %0b want 1", bus.ex_valid); end
        n_checks++; if (bus.ex_a !== 32'd9 || bus.ex_b !== 32'd9) begin n_fail++; $display("FAIL bypass_ex_ab: got %0d/%0d want 9/9", bus.ex_a, bus.ex_b); end
    endtask

    task automatic test_full_and_free();
        do_reset();
        drive(1, 0, 1, 2, 0, 0, 0, 0, 0, 0); tick();
        n_checks++; if (bus.issue_tag !== 5'b01001) begin n_fail++; $display("FAIL full_tag1: got %b want 01001", bus.issue_tag); end
        drive(1, 0, 3, 4, 0, 0, 0, 0, 0, 0); tick();
        n_checks++; if (bus.issue_tag !== 5'b01010 || bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_tag2: got %b/%0b want 01010/1", bus.issue_tag, bus.issue_ready); end
        drive(1, 0, 0, 6, 5'b00101, 0, 0, 0, 0, 0); tick();
        n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b want 0", bus.issue_ready); end
        drive(1, 0, 77, 88, 0, 0, 0, 0, 0, 0); tick();
        n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_held: got %0b want 0", bus.issue_ready); end
        n_checks++; if (bus.ex_tag !== 5'b01000 || bus.ex_a !== 32'd1 || bus.ex_b !== 32'd2) begin n_fail++; $display("FAIL full_locked: got %b %0d/%0d want 01000 1/2", bus.ex_tag, bus.ex_a, bus.ex_b); end
        drive(0, 0, 0, 0, 0, 0, 1, 5'b00101, 10, 1); tick();
        n_checks++; if (bus.ex_tag !== 5'b01001 || bus.ex_a !== 32'd3 || bus.ex_b !== 32'd4) begin n_fail++; $display("FAIL full_next1: got %b %0d/%0d want 01001 3/4", bus.ex_tag, bus.ex_a, bus.ex_b); end
        idle(1); tick();
        n_checks++; if (bus.ex_tag !== 5'b01010 || bus.ex_a !== 32'd10 || bus.ex_b !== 32'd6) begin n_fail++; $display("FAIL full_next2: got %b %0d/%0d want 01010 10/6", bus.ex_tag, bus.ex_a, bus.ex_b); end
        idle(1); tick();
        n_checks++; if (bus.ex_valid !== 1'b0 || bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_drained: ex_valid/ready got %0b/%0b want 0/0", bus.ex_valid, bus.issue_ready); end
        drive(1, 0, 55, 66, 0, 0, 1, 5'b01001, 0, 0); tick();
        n_checks++; if (bus.issue_ready !== 1'b1 || bus.issue_tag !== 5'b01001) begin n_fail++; $display("FAIL free_same_cycle: got %0b/%b want 1/01001", bus.issue_ready, bus.issue_tag); end
        n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL free_issue_ignored: ex_valid got %0b want 0", bus.ex_valid); end
        drive(0, 0, 0, 0, 0, 0, 1, 5'b01000, 0, 0); tick();
        n_checks++; if (bus.issue_tag !== 5'b01000) begin n_fail++; $display("FAIL free_entry0: got %b want 01000", bus.issue_tag); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 0, 1, 2, 0, 0, 0, 0, 0, 1); tick();
        drive(1, 0, 0, 4, 5'b00110, 0, 0, 0, 0, 1); tick();
        n_checks++; if (bus.issue_tag !== 5'b01010 || bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL mid_pre: got %b/%0b want 01010/0", bus.issue_tag, bus.ex_valid); end
        idle(0);
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++; if (bus.issue_ready !== 1'b1 || bus.issue_tag !== 5'b01000) begin n_fail++; $display("FAIL mid_reset_issue: got %0b/%b want 1/01000", bus.issue_ready, bus.issue_tag); end
        n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_tag !== 5'd0 || bus.ex_a !== 32'd0) begin n_fail++; $display("FAIL mid_reset_ex: got %0b/%b/%0d want 0/00000/0", bus.ex_valid, bus.ex_tag, bus.ex_a); end
        drive(0, 0, 0, 0, 0, 0, 1, 5'b01001, 123, 0); tick();
        n_checks++; if (bus.issue_tag !== 5'b01000 || bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_bcast: got %b/%0b want 01000/0", bus.issue_tag, bus.ex_valid); end
        drive(0, 0, 0, 0, 0, 0, 1, 5'b00110, 5, 0); tick();
        n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_wake: ex_valid got %0b want 0", bus.ex_valid); end
    endtask

    task automatic test_random();
        logic [4:0]  pool [6];
        logic        iv, op, cv, exr;
        logic [31:0] vj, vk, cd;
        logic [4:0]  qj, qk, ct;
        int          free_i;
        pool[0] = 5'b00101; pool[1] = 5'b10000; pool[2] = 5'b00110;
        pool[3] = 5'b01000; pool[4] = 5'b01001; pool[5] = 5'b01010;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            free_i = -1;
            for (int i = 0; i < C_N; i++) if (m_st[i] == S_FREE && free_i < 0) free_i = i;
            n_checks++; if (bus.issue_ready !== (free_i >= 0)) begin n_fail++; $display("FAIL rnd_ready @%0d: got %0b want %0b", cyc, bus.issue_ready, free_i >= 0); end
            if (free_i >= 0) begin
                n_checks++; if (bus.issue_tag !== 5'(8 + free_i)) begin n_fail++; $display("FAIL rnd_tag @%0d: got %b want %b", cyc, bus.issue_tag, 5'(8 + free_i)); end
            end
            n_checks++; if (bus.ex_valid !== m_exv) begin n_fail++; $display("FAIL rnd_ex_valid @%0d: got %0b want %0b", cyc, bus.ex_valid, m_exv); end
            if (m_exv) begin
                n_checks++;
                if (bus.ex_tag !== 5'(8 + m_exi) || bus.ex_op !== m_exop || bus.ex_a !== m_exa || bus.ex_b !== m_exb) begin
                    n_fail++;
                    $display("FAIL rnd_ex @%0d: got %b/%0b/%h/%h want %b/%0b/%h/%h", cyc, bus.ex_tag, bus.ex_op, bus.ex_a, bus.ex_b, 5'(8 + m_exi), m_exop, m_exa, m_exb);
                end
            end
            iv  = ($urandom_range(0, 1) == 1);
            op  = 1'($urandom_range(0, 1));
            vj  = $urandom; vk = $urandom; cd = $urandom;
            qj  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 5)] : 5'd0;
            qk  = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : 5'd0;
            cv  = ($urandom_range(0, 9) < 6);
            ct  = ($urandom_range(0, 7) == 0) ? 5'd0 : pool[$urandom_range(0, 5)];
            exr = ($urandom_range(0, 9) < 6);
            drive(iv, op, vj, vk, qj, qk, cv, ct, cd, exr);
            tick();
            model_step(iv, op, vj, vk, qj, qk, cv, ct, cd, exr);
        end
        idle(0);
    endtask

    initial begin
        rst = 1'b0;
        idle(0);
        @(negedge clk);
        test_reset();
        test_basic_issue();
        test_cdb_wakeup();
        test_bypass();
        test_full_and_free();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tomasulo_add_rs.md
# tomasulo_add_rs

Reservation station for the ADD execution unit of the Tomasulo CPU (station ID 3'b010). Accepts renamed add/sub instructions from the issue stage and snoops the common data bus (CDB) for pending operands. Dispatches ready entries to the adder, and frees each entry when its own result appears on the CDB. It sits between the issue/rename logic (upstream) and the ADD execution unit plus CDB (downstream).

## Interface
- RS_ID, 3'b010, station ID; forms the upper bits of every tag issued here.
- ENTRIES, 3, number of station entries (1..4).
- DATA_W, 32, operand/result width.
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  issue request this cycle.
- issue_op  in  1  0 = add, 1 = sub.
- issue_vj, issue_vk  in  DATA_W  operand values, meaningful when matching q is 0.
- issue_qj, issue_qk  in  5  producer tag ({station ID, index}); 5'b0 = value present.
- issue_ready  out  1  at least one FREE entry.
- issue_tag  out  5  tag the next accepted issue receives: {RS_ID, lowest FREE index}.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  5  broadcasting producer tag.
- cdb_data  in  DATA_W  broadcast value.
- ex_valid  out  1  an entry is presented to the adder.
- ex_ready  in  1  adder accepts this cycle.
- ex_op  out  1  operation of presented entry.
- ex_a, ex_b  out  DATA_W  Vj, Vk of presented entry.
- ex_tag  out  5  {RS_ID, index} of presented entry.

## Operation
- Per-entry state: FREE, WAIT (a q nonzero), READY (both q zero, not dispatched), EXEC (dispatched, awaiting own CDB broadcast). Entry fields: op, vj, vk, qj, qk.
- Issue fires on issue_valid && issue_ready. The lowest FREE index is loaded, and the state becomes READY if both resolved q are 0, otherwise WAIT. issue_valid with issue_ready=0 is ignored with no state change.
- Issue-time bypass: if cdb_valid and cdb_tag == issue_qj (nonzero), vj is loaded with cdb_data and qj is cleared. The same rule applies independently to qk.
- CDB snoop: for each WAIT entry, a nonzero q equal to cdb_tag captures cdb_data and clears to 0. Both qj and qk may resolve in the same broadcast. An entry transitions WAIT->READY when both q are 0 after the update.
- cdb_valid with cdb_tag == 0 is ignored.
- Dispatch select: if no entry is presented, the lowest-index READY entry becomes presented. A presented entry stays locked (ex_* held constant) until ex_valid && ex_ready, even if a lower-index entry becomes READY meanwhile.
- On handshake the presented entry becomes EXEC and the lock is released. A new selection may be presented the next cycle.
- EXEC->FREE when cdb_valid && cdb_tag == {RS_ID, index}. A READY or WAIT entry matching its own tag is not affected.
- Arithmetic is performed in the adder, not here. Operand values pass through unmodified.

## Timing
- Reset values:
  - all entries FREE, fields 0;
  - ex_valid=0, ex_op=0, ex_a=0, ex_b=0, ex_tag=0;
  - issue_ready=1, issue_tag={RS_ID,2'b00}.
- Reset asserted mid-operation discards all entries, including EXEC entries. A later CDB broadcast of a discarded tag is ignored.
- issue_ready and issue_tag are combinational from registered state only. An entry freed at edge N is issuable from cycle N+1 onward, never in the same cycle.
- Issue with operands available at edge N: ex_valid=1 in cycle N+1 if nothing else is presented. Minimum issue-to-dispatch latency is 1 cycle.
- CDB resolving the last operand at edge N: ex_valid for that entry in cycle N+1 at the earliest.
- ex_* are registered/held. They change only after a handshake edge or when ex_valid rises.
- Full (all entries non-FREE): issue_ready=0. Simultaneous free and issue request in the same cycle is not accepted that cycle.

## Test plan
- Reset, then issue add vj=5 vk=7 q=0,0 -> issue_tag=5'b01000 at issue, ex_valid=1 next cycle with ex_a=5, ex_b=7, ex_tag=5'b01000.
- Issue with qj=5'b00101 (MULT entry 1), vk=3. Broadcast cdb_tag=5'b00101, cdb_data=20 four cycles later -> ex_valid stays 0 until the cycle after the broadcast, then ex_a=20, ex_b=3.
- Issue with qj=qk=5'b10000 in the same cycle as cdb_tag=5'b10000, cdb_data=9 -> bypass captures both operands, ex_a=ex_b=9 next cycle.
- Fill 3 entries with ex_ready=0 -> issue_ready=0 and a 4th issue is ignored. The presented entry 0 stays on ex_* while entry 1 is READY.
- Accept entry 0, then broadcast cdb_tag=5'b01000 -> entry 0 FREE. issue_ready=1 and issue_tag=5'b01000 the following cycle.
- Assert reset while entries are in WAIT/EXEC -> all outputs return to reset values next cycle. A later broadcast of 5'b01001 has no effect.
